// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  localparam logic [31:0] TXDATA_OFS = 32'h0;
  localparam logic [31:0] STATUS_OFS = 32'h4;

  localparam int IDLE_B = 0;
  localparam int FULL_B = 1;
  localparam int OVF_B  = 2;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; dout shows the head entry combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    dout     = mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// Store-snooping UART transmitter: TXDATA/STATUS decode, sticky overflow, 8N1 serialiser.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] status_rd,
  output logic        sel,
  output logic        tx,
  output logic        busy
);
  localparam int BW = $clog2(CLKS_PER_BIT);

  tx_state_e      state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           ovf_q, ovf_d;

  logic           hit_tx, hit_st, push_req, baud_end, pop;
  logic           fifo_full, fifo_empty, idle;
  logic [7:0]     fifo_dout;
  logic           unused_wdata;

  assign unused_wdata = ^WriteData[31:8];

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   (WriteData[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    hit_tx   = (DataAdr == BASE_ADDR + TXDATA_OFS);
    hit_st   = (DataAdr == BASE_ADDR + STATUS_OFS);
    sel      = hit_tx || hit_st;
    push_req = MemWrite && hit_tx;
    idle     = fifo_empty && (state_q == IDLE);
    busy     = !idle;
    tx       = tx_q;

    status_rd = '0;
    if (hit_st) begin
      status_rd[IDLE_B] = idle;
      status_rd[FULL_B] = fifo_full;
      status_rd[OVF_B]  = ovf_q;
    end

    // A dropped push outranks a same-cycle clear so no loss goes unreported.
    ovf_d = ovf_q;
    if (MemWrite && hit_st && WriteData[OVF_B]) ovf_d = 1'b0;
    if (push_req && fifo_full) ovf_d = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    pop      = 1'b0;
    baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = START;
          tx_d    = 1'b0;
          baud_d  = '0;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: frame shape, back-to-back frames, overflow, decode, reset abort.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h100;
  localparam int CPB = 4;
  localparam int FD  = 4;

  logic        clk = 1'b0;
  logic        reset, MemWrite, sel, tx, busy;
  logic [31:0] DataAdr, WriteData, status_rd;

  int   n_chk = 0;
  int   n_err = 0;
  int   pcnt  = 0;
  logic log_tx   [0:4095];
  logic log_busy [0:4095];

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .status_rd (status_rd),
    .sel       (sel),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // log_*[p] holds the output seen after rising edge number p
  always @(posedge clk) pcnt <= pcnt + 1;
  always @(negedge clk) begin
    if (pcnt < 4096) begin
      log_tx[pcnt]   = tx;
      log_busy[pcnt] = busy;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] exp_frame(input logic [7:0] b);
    logic [39:0] f;
    for (int i = 0; i < 40; i++) begin
      int k;
      k = i / CPB;
      f[i] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
    end
    return f;
  endfunction

  task automatic store(input logic [31:0] addr, input logic [31:0] data, output int e);
    @(negedge clk);
    MemWrite  = 1'b1;
    DataAdr   = addr;
    WriteData = data;
    e         = pcnt + 1;
  endtask

  task automatic idle_bus();
    @(negedge clk);
    MemWrite  = 1'b0;
    DataAdr   = 32'h0;
    WriteData = 32'h0;
  endtask

  task automatic wait_to(input int idx);
    @(negedge clk);
    while (pcnt < idx) @(negedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int s, input logic [7:0] b);
    logic [39:0] obs;
    for (int i = 0; i < 40; i++) obs[i] = log_tx[s+i];
    chk(tag, {24'h0, obs}, {24'h0, exp_frame(b)});
  endtask

  task automatic check_quiet(input string tag, input int s);
    logic [39:0] obs;
    for (int i = 0; i < 40; i++) obs[i] = log_tx[s+i];
    chk(tag, {24'h0, obs}, {24'h0, 40'hFF_FFFF_FFFF});
  endtask

  initial begin
    int e, e0, dummy;
    reset     = 1'b0;
    MemWrite  = 1'b0;
    DataAdr   = 32'h0;
    WriteData = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b1;

    // Reset state as seen through the bus
    @(negedge clk);
    DataAdr = BASE + 32'h4;
    #1;
    chk("init_status", status_rd, 32'h1);
    chk("init_sel", sel, 1'b1);
    chk("init_tx", tx, 1'b1);
    chk("init_busy", busy, 1'b0);
    DataAdr = BASE;
    #1;
    chk("txdata_status_zero", status_rd, 32'h0);

    // Single frame with upper data bits set
    store(BASE, 32'hFFFF_FFA5, e);
    idle_bus();
    wait_to(e + 41);
    chk("a5_pre_start_tx", log_tx[e], 1'b1);
    chk("a5_busy_queued", log_busy[e], 1'b1);
    check_frame("a5_frame", e + 1, 8'hA5);
    chk("a5_busy_last_stop", log_busy[e + 40], 1'b1);
    chk("a5_busy_after", log_busy[e + 41], 1'b0);

    // Five back-to-back stores: contiguous frames, no overflow
    store(BASE, 32'h11, e0);
    for (int k = 1; k < 5; k++) store(BASE, 32'h11 + k, dummy);
    idle_bus();
    DataAdr = BASE + 32'h4;
    #1;
    chk("b2b_status_full", status_rd, 32'h2);
    wait_to(e0 + 201);
    for (int k = 0; k < 5; k++)
      check_frame($sformatf("b2b_frame%0d", k), e0 + 1 + 40*k, 8'h11 + k);
    chk("b2b_busy_after", log_busy[e0 + 201], 1'b0);
    DataAdr = BASE + 32'h4;
    #1;
    chk("b2b_status_end", status_rd, 32'h1);

    // Six stores: sixth dropped, overflow sticky, clear, unmapped address
    store(BASE, 32'h21, e0);
    for (int k = 1; k < 6; k++) store(BASE, 32'h21 + k, dummy);
    idle_bus();
    DataAdr = BASE + 32'h4;
    #1;
    chk("ovf_status_set", status_rd, 32'h6);
    store(BASE + 32'h4, 32'h4, dummy);
    idle_bus();
    DataAdr = BASE + 32'h4;
    #1;
    chk("ovf_status_clr", status_rd, 32'h2);
    store(BASE + 32'h8, 32'h99, dummy);
    #1;
    chk("unmapped_sel", sel, 1'b0);
    chk("unmapped_status", status_rd, 32'h0);
    idle_bus();
    wait_to(e0 + 241);
    for (int k = 0; k < 5; k++)
      check_frame($sformatf("ovf_frame%0d", k), e0 + 1 + 40*k, 8'h21 + k);
    chk("ovf_busy_after", log_busy[e0 + 201], 1'b0);
    check_quiet("ovf_no_extra", e0 + 201);

    // Reset during data bit 3 of 0x5A with 0x77 still queued
    store(BASE, 32'h5A, e);
    store(BASE, 32'h77, dummy);
    idle_bus();
    wait_to(e + 18);
    chk("abort_busy_before", busy, 1'b1);
    reset   = 1'b0;
    DataAdr = BASE + 32'h4;
    #1;
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_status", status_rd, 32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    store(BASE, 32'h3C, e);
    idle_bus();
    wait_to(e + 81);
    check_frame("post_rst_frame", e + 1, 8'h3C);
    chk("post_rst_busy", log_busy[e + 41], 1'b0);
    check_quiet("post_rst_quiet", e + 41);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
